moving_avg_filter: RTL and testbench

- Parametrised boxcar moving-average filter: running mean of the last 2^LOG2_TAPS accepted samples of an unsigned stream.
- Sits in the sample datapath between a sample source (ADC or switch input) and display/output logic.
- Adds over the fixed 4-tap, 8-bit filter: width/depth generics, a valid qualifier, full-precision running sum, priming flag and bypass mode.

---
 rtl/moving_avg_if.sv | 22 ++
 rtl/moving_avg_filter.sv | 62 ++++++
 tb/tb_moving_avg_filter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/moving_avg_if.sv
// Sample stream bundle between a sample source and the moving-average filter.
// The master side drives samples; the slave side returns the filtered stream.
interface moving_avg_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] x;
    logic              bypass;
    logic              out_valid;
    logic [DATA_W-1:0] y;
    logic              primed;

    modport master (
        output in_valid, x, bypass,
        input  out_valid, y, primed
    );

    modport slave (
        input  in_valid, x, bypass,
        output out_valid, y, primed
    );
endinterface

// File: rtl/moving_avg_filter.sv
// Boxcar moving average over the last 2^LOG2_TAPS accepted samples.
// Keeps a full-precision running sum next to a circular history buffer.
module moving_avg_filter #(
    parameter int DATA_W    = 8,
    parameter int LOG2_TAPS = 2
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    moving_avg_if.slave bus
);
    localparam int TAPS  = 1 << LOG2_TAPS;
    localparam int SUM_W = DATA_W + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0]   FILL_MAX = (LOG2_TAPS+1)'(TAPS);
    localparam logic [LOG2_TAPS:0]   FILL_ONE = (LOG2_TAPS+1)'(1);
    localparam logic [LOG2_TAPS-1:0] PTR_ONE  = LOG2_TAPS'(1);

    logic [DATA_W-1:0]    hist [TAPS];
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     sum_next;
    logic [LOG2_TAPS-1:0] wr_ptr;
    logic [LOG2_TAPS:0]   fill;
    logic [DATA_W-1:0]    y_r;
    logic                 out_valid_r;
    logic                 primed_r;

    // Modular arithmetic: intermediate wrap cancels, result always fits SUM_W.
    always_comb begin
        sum_next = sum + SUM_W'(bus.x) - SUM_W'(hist[wr_ptr]);
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
            sum         <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            y_r         <= '0;
            out_valid_r <= 1'b0;
            primed_r    <= 1'b0;
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                hist[wr_ptr] <= bus.x;
                wr_ptr       <= wr_ptr + PTR_ONE;
                sum          <= sum_next;
                y_r          <= bus.bypass ? bus.x : sum_next[SUM_W-1:LOG2_TAPS];
                if (fill != FILL_MAX) begin
                    fill <= fill + FILL_ONE;
                end
                if (fill == FILL_MAX - FILL_ONE) begin
                    primed_r <= 1'b1;
                end
            end
        end
    end

    assign bus.y         = y_r;
    assign bus.out_valid = out_valid_r;
    assign bus.primed    = primed_r;
endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed and scoreboard checks of moving_avg_filter in the default
// 8-bit/4-tap configuration and a 12-bit/8-tap configuration.
module tb_moving_avg_filter;
    logic CLOCK_50 = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    moving_avg_if #(.DATA_W(8))  ifa ();
    moving_avg_if #(.DATA_W(12)) ifb ();

    moving_avg_filter #(.DATA_W(8), .LOG2_TAPS(2)) dut_a (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (ifa.slave)
    );

    moving_avg_filter #(.DATA_W(12), .LOG2_TAPS(3)) dut_b (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .bus      (ifb.slave)
    );

    // sel 0 drives the 8-bit instance, sel 1 the 12-bit one; the other idles
    task automatic drive(input int sel, input logic v, input int xv, input logic bp);
        ifa.in_valid = (sel == 0) && v;
        ifa.x        = (sel == 0) ? 8'(xv) : 8'd0;
        ifa.bypass   = (sel == 0) && bp;
        ifb.in_valid = (sel == 1) && v;
        ifb.x        = (sel == 1) ? 12'(xv) : 12'd0;
        ifb.bypass   = (sel == 1) && bp;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b1, 'hAA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifa.y !== 8'd0 || ifa.out_valid !== 1'b0 || ifa.primed !== 1'b0) begin
                failures++;
                $display("FAIL reset[%0d] y=%0d ov=%0b pr=%0b expected y=0 ov=0 pr=0",
                         i, ifa.y, ifa.out_valid, ifa.primed);
            end
        end
        rst = 1'b0;
        drive(0, 1'b1, 8, 1'b0);
        tick();
        checks++;
        if (ifa.y !== 8'd2 || ifa.out_valid !== 1'b1 || ifa.primed !== 1'b0) begin
            failures++;
            $display("FAIL reset_first y=%0d ov=%0b pr=%0b expected y=2 ov=1 pr=0",
                     ifa.y, ifa.out_valid, ifa.primed);
        end
        drive(0, 1'b0, 0, 1'b0);
        tick();
        checks++;
        if (ifa.y !== 8'd2 || ifa.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle y=%0d ov=%0b expected y=2 ov=0", ifa.y, ifa.out_valid);
        end
    endtask

    task automatic test_ramp();
        int ey [6] = '{50, 100, 150, 200, 200, 200};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 200, 1'b0);
            tick();
            checks++;
            if (ifa.y !== ey[i][7:0] || ifa.out_valid !== 1'b1 || ifa.primed !== (i >= 3)) begin
                failures++;
                $display("FAIL ramp[%0d] y=%0d ov=%0b pr=%0b expected y=%0d ov=1 pr=%0b",
                         i, ifa.y, ifa.out_valid, ifa.primed, ey[i], (i >= 3));
            end
        end
    endtask

    task automatic test_full_scale();
        int ey [12] = '{63, 127, 191, 255, 255, 255, 255, 255, 191, 127, 63, 0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(0, 1'b1, (i < 8) ? 255 : 0, 1'b0);
            tick();
            checks++;
            if (ifa.y !== ey[i][7:0] || ifa.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL full_scale[%0d] y=%0d ov=%0b expected y=%0d ov=1",
                         i, ifa.y, ifa.out_valid, ey[i]);
            end
        end
    endtask

    task automatic test_gapped();
        int xs [7]  = '{40, 0, 80, 0, 0, 120, 160};
        bit vs [7]  = '{1, 0, 1, 0, 0, 1, 1};
        int ey [7]  = '{10, 10, 30, 30, 30, 60, 100};
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(0, vs[i], xs[i], 1'b0);
            tick();
            if (ifa.out_valid === 1'b1) pulses++;
            checks++;
            if (ifa.y !== ey[i][7:0] || ifa.out_valid !== vs[i]) begin
                failures++;
                $display("FAIL gapped[%0d] y=%0d ov=%0b expected y=%0d ov=%0b",
                         i, ifa.y, ifa.out_valid, ey[i], vs[i]);
            end
        end
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL gapped_pulses got=%0d expected=4", pulses);
        end
    endtask

    task automatic test_bypass();
        int ey [6] = '{25, 50, 75, 100, 20, 60};
        bit bp [6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, (i < 4) ? 100 : 20, bp[i]);
            tick();
            checks++;
            if (ifa.y !== ey[i][7:0] || ifa.primed !== (i >= 3)) begin
                failures++;
                $display("FAIL bypass[%0d] y=%0d pr=%0b expected y=%0d pr=%0b",
                         i, ifa.y, ifa.primed, ey[i], (i >= 3));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 255, 1'b0);
            tick();
        end
        checks++;
        if (ifa.y !== 8'd255 || ifa.primed !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre y=%0d pr=%0b expected y=255 pr=1", ifa.y, ifa.primed);
        end
        rst = 1'b1;
        drive(0, 1'b1, 255, 1'b0);
        tick();
        checks++;
        if (ifa.y !== 8'd0 || ifa.out_valid !== 1'b0 || ifa.primed !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst y=%0d ov=%0b pr=%0b expected y=0 ov=0 pr=0",
                     ifa.y, ifa.out_valid, ifa.primed);
        end
        rst = 1'b0;
        drive(0, 1'b1, 8, 1'b0);
        tick();
        checks++;
        if (ifa.y !== 8'd2 || ifa.primed !== 1'b0) begin
            failures++;
            $display("FAIL mid_after y=%0d pr=%0b expected y=2 pr=0", ifa.y, ifa.primed);
        end
    endtask

    task automatic test_wide();
        int ey [12] = '{511, 1023, 1535, 2047, 2559, 3071, 3583, 4095, 3583, 3071, 2559, 2047};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1, 1'b1, (i < 8) ? 4095 : 0, 1'b0);
            tick();
            checks++;
            if (ifb.y !== ey[i][11:0] || ifb.out_valid !== 1'b1 || ifb.primed !== (i >= 7)) begin
                failures++;
                $display("FAIL wide[%0d] y=%0d ov=%0b pr=%0b expected y=%0d ov=1 pr=%0b",
                         i, ifb.y, ifb.out_valid, ifb.primed, ey[i], (i >= 7));
            end
        end
    endtask

    // Reference model recomputes the window sum from scratch each sample
    task automatic test_back_to_back(input int sel, input int n);
        int   win [64];
        int   ptr = 0;
        int   cnt = 0;
        int   last_y = 0;
        int   taps, sh, maxv, s, xv, act_y;
        logic v, bp, act_ov, act_pr;
        taps = (sel == 1) ? 8 : 4;
        sh   = (sel == 1) ? 3 : 2;
        maxv = (sel == 1) ? 4095 : 255;
        foreach (win[i]) win[i] = 0;
        do_reset();
        for (int k = 0; k < n; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            bp = ($urandom_range(0, 4) == 0);
            xv = int'($urandom_range(0, maxv));
            drive(sel, v, xv, bp);
            tick();
            if (v) begin
                win[ptr] = xv;
                ptr = (ptr + 1) % taps;
                s = 0;
                for (int j = 0; j < taps; j++) s += win[j];
                last_y = bp ? xv : (s >> sh);
                cnt++;
            end
            act_y  = (sel == 1) ? int'(ifb.y) : int'(ifa.y);
            act_ov = (sel == 1) ? ifb.out_valid : ifa.out_valid;
            act_pr = (sel == 1) ? ifb.primed : ifa.primed;
            checks++;
            if (act_y != last_y || act_ov !== v || act_pr !== (cnt >= taps)) begin
                failures++;
                $display("FAIL scoreboard%0d[%0d] y=%0d ov=%0b pr=%0b expected y=%0d ov=%0b pr=%0b",
                         sel, k, act_y, act_ov, act_pr, last_y, v, (cnt >= taps));
            end
        end
    endtask

    initial begin
        drive(0, 1'b0, 0, 1'b0);
        test_reset();
        test_ramp();
        test_full_scale();
        test_gapped();
        test_bypass();
        test_mid_reset();
        test_wide();
        test_back_to_back(0, 200);
        test_back_to_back(1, 200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
